// File: rtl/mem_access_stage_if.sv
// Data-bus bundle between the MEM stage (master) and the memory/bus fabric (slave).
// The stage drives the request side; the fabric answers with ack and read data.
interface mem_access_stage_if;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [3:0]  bus_wstrb;
  logic        bus_ack;
  logic [31:0] bus_rdata;

  modport master (
    output bus_req, bus_we, bus_addr, bus_wdata, bus_wstrb,
    input  bus_ack, bus_rdata
  );

  modport slave (
    input  bus_req, bus_we, bus_addr, bus_wdata, bus_wstrb,
    output bus_ack, bus_rdata
  );
endinterface

// File: rtl/mem_access_stage.sv
// Pipeline MEM stage: issues loads/stores over a req/ack bus, formats load data,
// guards the access with a timeout and registers results into the MEM/WB boundary.
module mem_access_stage #(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int CNT_W          = 5
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      ex_valid,
  input  logic [31:0]               ex_c,
  input  logic [31:0]               ex_rD2,
  input  logic                      ex_mem_rd,
  input  logic                      ex_mem_wr,
  input  logic [2:0]                ex_funct3,
  input  logic [4:0]                ex_rd,
  input  logic                      ex_rf_we,
  output logic                      stall,
  mem_access_stage_if.master        bus,
  output logic                      wb_valid,
  output logic [31:0]               wb_data,
  output logic [4:0]                wb_rd,
  output logic                      wb_rf_we,
  output logic                      mem_err
);

  localparam int DATA_W = 32;

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [1:0]       lane_p1;
  logic [2:0]       f3_p1;
  logic [4:0]       rd_p1;
  logic             rf_we_p1;
  logic             is_mem, f3_legal, misaligned, access_ok, accept, timeout_hit;

  function automatic logic [DATA_W-1:0] store_lanes(input logic [DATA_W-1:0] data,
                                                    input logic [1:0] size);
    case (size)
      2'b00:   store_lanes = {4{data[7:0]}};
      2'b01:   store_lanes = {2{data[15:0]}};
      default: store_lanes = data;
    endcase
  endfunction

  function automatic logic [3:0] store_strobe(input logic [1:0] lane, input logic [1:0] size);
    case (size)
      2'b00:   store_strobe = 4'b0001 << lane;
      2'b01:   store_strobe = 4'b0011 << lane;
      default: store_strobe = 4'b1111;
    endcase
  endfunction

  function automatic logic [DATA_W-1:0] load_fmt(input logic [DATA_W-1:0] word,
                                                 input logic [1:0] lane,
                                                 input logic [2:0] f3);
    logic        [DATA_W-1:0] shifted;
    logic signed [7:0]        b;
    logic signed [15:0]       h;
    logic signed [DATA_W-1:0] ext;
    shifted = word >> {lane, 3'b000};
    b       = shifted[7:0];
    h       = shifted[15:0];
    ext     = '0;
    case (f3)
      3'b000: begin ext = b; load_fmt = ext; end
      3'b001: begin ext = h; load_fmt = ext; end
      3'b100: load_fmt = {24'b0, shifted[7:0]};
      3'b101: load_fmt = {16'b0, shifted[15:0]};
      default: load_fmt = word;
    endcase
  endfunction

  // Access qualification: a simultaneous load+store request is never legal
  always_comb begin
    is_mem   = ex_mem_rd | ex_mem_wr;
    f3_legal = 1'b0;
    if (ex_mem_rd && !ex_mem_wr)
      f3_legal = ex_funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    else if (ex_mem_wr && !ex_mem_rd)
      f3_legal = ex_funct3 inside {3'b000, 3'b001, 3'b010};
    misaligned = 1'b0;
    case (ex_funct3[1:0])
      2'b01:   misaligned = ex_c[0];
      2'b10:   misaligned = |ex_c[1:0];
      default: misaligned = 1'b0;
    endcase
    access_ok   = f3_legal & ~misaligned;
    accept      = (state == IDLE) & ex_valid & is_mem & access_ok;
    timeout_hit = (cnt == CNT_W'(TIMEOUT_CYCLES - 1));
  end

  // Stall drops in the ack cycle and in the abort cycle so EX retires the instruction
  always_comb begin
    state_nxt = state;
    stall     = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          stall     = 1'b1;
          state_nxt = BUSY;
        end
      end
      BUSY: begin
        stall = ~bus.bus_ack & ~timeout_hit;
        if (bus.bus_ack || timeout_hit)
          state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // p1 boundary: access attributes latched at accept, used when the ack returns
  always_ff @(posedge clk) begin
    if (accept) begin
      lane_p1  <= ex_c[1:0];
      f3_p1    <= ex_funct3;
      rd_p1    <= ex_rd;
      rf_we_p1 <= ex_rf_we & ~ex_mem_wr;
    end
  end

  // MEM/WB boundary and bus request registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      cnt           <= '0;
      bus.bus_req   <= 1'b0;
      bus.bus_we    <= 1'b0;
      bus.bus_addr  <= '0;
      bus.bus_wdata <= '0;
      bus.bus_wstrb <= '0;
      wb_valid      <= 1'b0;
      wb_data       <= '0;
      wb_rd         <= '0;
      wb_rf_we      <= 1'b0;
      mem_err       <= 1'b0;
    end else begin
      state    <= state_nxt;
      wb_valid <= 1'b0;
      mem_err  <= 1'b0;
      case (state)
        IDLE: begin
          if (ex_valid && !is_mem) begin
            wb_valid <= 1'b1;
            wb_data  <= ex_c;
            wb_rd    <= ex_rd;
            wb_rf_we <= ex_rf_we;
          end else if (accept) begin
            bus.bus_req   <= 1'b1;
            bus.bus_we    <= ex_mem_wr;
            bus.bus_addr  <= {ex_c[31:2], 2'b00};
            bus.bus_wdata <= store_lanes(ex_rD2, ex_funct3[1:0]);
            bus.bus_wstrb <= ex_mem_wr ? store_strobe(ex_c[1:0], ex_funct3[1:0]) : 4'b0000;
            cnt           <= '0;
          end else if (ex_valid) begin
            mem_err  <= 1'b1;
            wb_valid <= 1'b1;
            wb_data  <= ex_c;
            wb_rd    <= ex_rd;
            wb_rf_we <= 1'b0;
          end
        end
        BUSY: begin
          if (bus.bus_ack) begin
            bus.bus_req <= 1'b0;
            wb_valid    <= 1'b1;
            wb_data     <= bus.bus_we ? '0 : load_fmt(bus.bus_rdata, lane_p1, f3_p1);
            wb_rd       <= rd_p1;
            wb_rf_we    <= rf_we_p1;
            cnt         <= '0;
          end else if (timeout_hit) begin
            bus.bus_req <= 1'b0;
            mem_err     <= 1'b1;
            wb_valid    <= 1'b1;
            wb_rd       <= rd_p1;
            wb_rf_we    <= 1'b0;
            cnt         <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// Scoreboard bench for mem_access_stage: a driver issues EX instructions and plays the
// bus, pushing expected MEM/WB entries; a monitor pops and compares on each wb_valid.
module tb_mem_access_stage;
  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_valid, ex_mem_rd, ex_mem_wr, ex_rf_we;
  logic [31:0] ex_c, ex_rD2;
  logic [2:0]  ex_funct3;
  logic [4:0]  ex_rd;
  logic        stall, wb_valid, wb_rf_we, mem_err;
  logic [31:0] wb_data;
  logic [4:0]  wb_rd;

  mem_access_stage_if bus();

  mem_access_stage #(.TIMEOUT_CYCLES(TO), .CNT_W(5)) dut (
    .clk(clk), .rst(rst), .ex_valid(ex_valid), .ex_c(ex_c), .ex_rD2(ex_rD2),
    .ex_mem_rd(ex_mem_rd), .ex_mem_wr(ex_mem_wr), .ex_funct3(ex_funct3), .ex_rd(ex_rd),
    .ex_rf_we(ex_rf_we), .stall(stall), .bus(bus), .wb_valid(wb_valid), .wb_data(wb_data),
    .wb_rd(wb_rd), .wb_rf_we(wb_rf_we), .mem_err(mem_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    logic        chk_data;
    logic [4:0]  rd;
    logic        rf_we;
    logic        err;
  } exp_t;

  exp_t q[$];
  exp_t m_e;
  int   vectors = 0;
  int   miscompares = 0;
  bit   mon_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push(input logic [31:0] data, input logic chk_data, input logic [4:0] rd,
                      input logic rf_we, input logic err);
    exp_t e;
    e.data = data; e.chk_data = chk_data; e.rd = rd; e.rf_we = rf_we; e.err = err;
    q.push_back(e);
  endtask

  // Reference rules computed arithmetically from access size and byte offset
  function automatic bit model_legal(input logic r, input logic w, input logic [2:0] f3,
                                     input logic [31:0] c);
    int size;
    if (r && w) return 1'b0;
    if (r && !(f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5})) return 1'b0;
    if (w && !(f3 inside {3'd0, 3'd1, 3'd2})) return 1'b0;
    size = 1 << f3[1:0];
    return (c % size) == 0;
  endfunction

  function automatic logic [31:0] model_load(input logic [31:0] word, input logic [31:0] c,
                                             input logic [2:0] f3);
    int sh;
    int v;
    sh = int'(c % 4) * 8;
    case (f3)
      3'd0: begin v = int'((word >> sh) & 32'hFF);   if (v >= 128)   v = v - 256;   end
      3'd1: begin v = int'((word >> sh) & 32'hFFFF); if (v >= 32768) v = v - 65536; end
      3'd4: v = int'((word >> sh) & 32'hFF);
      3'd5: v = int'((word >> sh) & 32'hFFFF);
      default: v = int'(word);
    endcase
    return 32'(v);
  endfunction

  function automatic logic [31:0] model_wdata(input logic [31:0] d, input logic [2:0] f3);
    case (f3)
      3'd0:    return (d & 32'hFF) * 32'h0101_0101;
      3'd1:    return (d & 32'hFFFF) * 32'h0001_0001;
      default: return d;
    endcase
  endfunction

  function automatic logic [31:0] model_strb(input logic [31:0] c, input logic [2:0] f3);
    int size;
    size = 1 << f3[1:0];
    return 32'((((1 << size) - 1) << (c % 4)) & 15);
  endfunction

  // Called just after a falling edge with the DUT idle; returns just after the falling
  // edge at which the instruction's wb entry is visible. dly >= TO means never ack.
  task automatic do_op(input logic r, input logic w, input logic [2:0] f3,
                       input logic [31:0] c, input logic [31:0] d2, input logic [4:0] rd,
                       input logic rfwe, input int dly, input logic [31:0] rdata);
    ex_valid = 1'b1; ex_mem_rd = r; ex_mem_wr = w; ex_funct3 = f3;
    ex_c = c; ex_rD2 = d2; ex_rd = rd; ex_rf_we = rfwe;
    if (!(r || w)) begin
      push(c, 1'b1, rd, rfwe, 1'b0);
      #1 chk("alu_stall", stall, 0);
      @(negedge clk);
      ex_valid = 1'b0;
      return;
    end
    if (!model_legal(r, w, f3, c)) begin
      push(c, 1'b0, rd, 1'b0, 1'b1);
      #1 chk("err_stall", stall, 0);
      @(negedge clk);
      chk("err_no_req", bus.bus_req, 0);
      ex_valid = 1'b0;
      return;
    end
    #1 chk("accept_stall", stall, 1);
    @(negedge clk);
    chk("req_up", bus.bus_req, 1);
    chk("bus_we", bus.bus_we, w);
    chk("bus_wstrb", bus.bus_wstrb, w ? model_strb(c, f3) : 32'd0);
    if (w) chk("bus_wdata", bus.bus_wdata, model_wdata(d2, f3));
    for (int i = 0; i < TO; i++) begin
      chk("bus_addr", bus.bus_addr, c & 32'hFFFF_FFFC);
      if (i == dly) begin
        bus.bus_ack = 1'b1; bus.bus_rdata = rdata;
        push(w ? 32'd0 : model_load(rdata, c, f3), r, rd, r ? rfwe : 1'b0, 1'b0);
        #1 chk("ack_stall", stall, 0);
        @(negedge clk);
        bus.bus_ack = 1'b0; ex_valid = 1'b0;
        chk("req_down_ack", bus.bus_req, 0);
        return;
      end
      chk("req_held", bus.bus_req, 1);
      if (i == TO - 1) push(32'd0, 1'b0, rd, 1'b0, 1'b1);
      else #1 chk("busy_stall", stall, 1);
      @(negedge clk);
    end
    ex_valid = 1'b0;
    chk("req_down_timeout", bus.bus_req, 0);
  endtask

  // Monitor: every wb entry must match the head of the scoreboard
  always @(negedge clk) begin
    if (mon_en && !rst) begin
      if (!wb_valid) begin
        chk("mem_err_without_wb", mem_err, 0);
      end else if (q.size() == 0) begin
        chk("wb_unexpected", wb_valid, 0);
      end else begin
        m_e = q.pop_front();
        chk("wb_rd", wb_rd, m_e.rd);
        chk("wb_rf_we", wb_rf_we, m_e.rf_we);
        chk("mem_err", mem_err, m_e.err);
        if (m_e.chk_data) chk("wb_data", wb_data, m_e.data);
      end
    end
  end

  initial begin
    logic [2:0]  f3;
    logic [31:0] c, d2, rdata;
    logic [4:0]  rd;
    logic        r, w, rfwe;
    int          kind, dly;

    rst = 1'b1; ex_valid = 1'b0; ex_mem_rd = 1'b0; ex_mem_wr = 1'b0; ex_rf_we = 1'b0;
    ex_c = '0; ex_rD2 = '0; ex_funct3 = '0; ex_rd = '0;
    bus.bus_ack = 1'b0; bus.bus_rdata = '0;
    repeat (2) @(negedge clk);
    chk("rst_bus_req", bus.bus_req, 0);
    chk("rst_bus_we", bus.bus_we, 0);
    chk("rst_bus_addr", bus.bus_addr, 0);
    chk("rst_bus_wdata", bus.bus_wdata, 0);
    chk("rst_bus_wstrb", bus.bus_wstrb, 0);
    chk("rst_wb_valid", wb_valid, 0);
    chk("rst_wb_data", wb_data, 0);
    chk("rst_wb_rd", wb_rd, 0);
    chk("rst_wb_rf_we", wb_rf_we, 0);
    chk("rst_mem_err", mem_err, 0);
    chk("rst_stall", stall, 0);
    rst = 1'b0;
    mon_en = 1'b1;
    @(negedge clk);

    do_op(1'b0, 1'b0, 3'd0, 32'h0000_1234, 32'h0, 5'd5, 1'b1, 0, 32'h0);
    chk("alu_wb_data", wb_data, 32'h0000_1234);
    chk("alu_wb_rd", wb_rd, 5);
    @(negedge clk);

    do_op(1'b1, 1'b0, 3'd0, 32'h0000_0103, 32'h0, 5'd7, 1'b1, 3, 32'h80FF_0000);
    chk("lb_wb_data", wb_data, 32'hFFFF_FF80);

    do_op(1'b0, 1'b1, 3'd1, 32'h0000_0202, 32'hAAAA_BEEF, 5'd3, 1'b1, 1, 32'h0);
    chk("sh_wb_rf_we", wb_rf_we, 0);

    do_op(1'b1, 1'b0, 3'd2, 32'h0000_0301, 32'h0, 5'd9, 1'b1, 0, 32'h0);
    chk("mis_mem_err", mem_err, 1);
    chk("mis_wb_valid", wb_valid, 1);
    chk("mis_wb_rf_we", wb_rf_we, 0);
    @(negedge clk);

    do_op(1'b1, 1'b0, 3'd2, 32'h0000_0400, 32'h0, 5'd10, 1'b1, 99, 32'h0);
    chk("to_mem_err", mem_err, 1);
    chk("to_wb_valid", wb_valid, 1);
    @(negedge clk);
    chk("to_idle_no_req", bus.bus_req, 0);

    do_op(1'b1, 1'b0, 3'd2, 32'h0000_0500, 32'h0, 5'd11, 1'b1, TO - 1, 32'h1234_5678);
    chk("late_ack_no_err", mem_err, 0);
    chk("late_ack_wb_data", wb_data, 32'h1234_5678);

    // Reset while the bus waits, then a stray ack
    ex_valid = 1'b1; ex_mem_rd = 1'b1; ex_mem_wr = 1'b0; ex_funct3 = 3'd2;
    ex_c = 32'h0000_0600; ex_rd = 5'd12; ex_rf_we = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_busy_req", bus.bus_req, 0);
    chk("rst_busy_wb_valid", wb_valid, 0);
    rst = 1'b0; ex_valid = 1'b0;
    bus.bus_ack = 1'b1; bus.bus_rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    bus.bus_ack = 1'b0;
    chk("stray_ack_wb_valid", wb_valid, 0);
    @(negedge clk);
    chk("stray_ack_wb_valid2", wb_valid, 0);

    for (int n = 0; n < 80; n++) begin
      kind = $urandom_range(0, 9);
      r = (kind inside {[3:5], 9});
      w = (kind inside {[6:8], 9});
      f3 = 3'($urandom_range(0, 7));
      c = $urandom;
      if ($urandom_range(0, 1) == 1) c[1:0] = 2'b00;
      d2 = $urandom; rd = 5'($urandom); rfwe = 1'($urandom); rdata = $urandom;
      dly = ($urandom_range(0, 14) == 0) ? 99 : $urandom_range(0, 4);
      do_op(r, w, f3, c, d2, rd, rfwe, dly, rdata);
      repeat ($urandom_range(0, 2)) begin
        bus.bus_ack = 1'($urandom);
        @(negedge clk);
        bus.bus_ack = 1'b0;
      end
    end

    repeat (3) @(negedge clk);
    chk("pending_entries", q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
